// File: rtl/counter_seq_ctrl_if.sv
// Command handshake between a host and the counter sequencer.
//   cmd_valid  : host has a command
//   cmd_ready  : sequencer can accept a command
//   cmd_start  : value loaded into the counter
//   cmd_target : terminal count value
//   cmd_up     : 1 = count up, 0 = count down
//   cmd_gap    : idle cycles between consecutive count-enable pulses
interface counter_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_target;
  logic             cmd_up;
  logic [GAP_W-1:0] cmd_gap;

  modport master (
    output cmd_valid, cmd_start, cmd_target, cmd_up, cmd_gap,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_target, cmd_up, cmd_gap,
    output cmd_ready
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for a loadable up/down counter. Accepts one command at a time, loads the
// counter with the start value, then issues single count-enable steps (separated by a
// programmable gap) until the counter reaches the target. Reports done, abort and wrap status.
//   clk, rst_n       : clock and asynchronous active-low reset (shared with the counter)
//   cmd              : command handshake (slave side)
//   abort            : cancel the active command
//   load_n/data_load : counter synchronous load (active-low) and load value
//   ce/up_down       : counter count enable and direction
//   count_out        : counter value; max_count/zero are its all-ones/zero flags
//   busy             : command in progress
//   done/aborted     : one-cycle completion / cancellation pulses
//   wrapped          : sticky per command, a step crossed the max<->0 boundary
module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  counter_seq_ctrl_if.slave cmd,
  input  logic              abort,
  output logic              load_n,
  output logic [WIDTH-1:0]  data_load,
  output logic              ce,
  output logic              up_down,
  input  logic [WIDTH-1:0]  count_out,
  input  logic              max_count,
  input  logic              zero,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              wrapped
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] start_q, target_q;
  logic             up_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             wrapped_q, wrapped_d;
  logic             aborted_q, aborted_d;
  logic             accept;
  logic             at_target;
  logic             run_active;
  logic             step;

  assign accept     = (state_q == StIdle) && cmd.cmd_valid;
  // count_out already reflects every earlier step, so stopping on equality cannot overshoot.
  assign at_target  = (count_out == target_q);
  assign run_active = (state_q == StRun) && !abort && !at_target;
  assign step       = run_active && (gap_cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd.cmd_valid) state_d = StLoad;
      // The load always completes; an abort only redirects what follows it.
      StLoad: state_d = abort ? StIdle : StRun;
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (at_target) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Gap counter, wrap flag and abort pulse next-state
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    wrapped_d = wrapped_q;
    aborted_d = abort && ((state_q == StLoad) || (state_q == StRun));
    if (accept) begin
      wrapped_d = 1'b0;
    end
    if (state_q == StLoad) begin
      gap_cnt_d = gap_q;
    end
    if (run_active) begin
      if (step) begin
        gap_cnt_d = gap_q;
        // The step taken from the boundary value is the one that wraps.
        if ((up_q && max_count) || (!up_q && zero)) begin
          wrapped_d = 1'b1;
        end
      end else begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
    end
  end

  // Latched command fields and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= '0;
      target_q  <= '0;
      up_q      <= 1'b0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      wrapped_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (accept) begin
        start_q  <= cmd.cmd_start;
        target_q <= cmd.cmd_target;
        up_q     <= cmd.cmd_up;
        gap_q    <= cmd.cmd_gap;
      end
      gap_cnt_q <= gap_cnt_d;
      wrapped_q <= wrapped_d;
      aborted_q <= aborted_d;
    end
  end

  // Output decode
  always_comb begin
    cmd.cmd_ready = (state_q == StIdle);
    load_n        = 1'b1;
    data_load     = '0;
    ce            = 1'b0;
    up_down       = 1'b1;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        load_n    = 1'b0;
        data_load = start_q;
        up_down   = up_q;
        busy      = 1'b1;
      end
      StRun: begin
        ce      = step;
        up_down = up_q;
        busy    = 1'b1;
      end
      StDone: begin
        up_down = up_q;
        busy    = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign aborted = aborted_q;
  assign wrapped = wrapped_q;

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Command sequencer for the loadable up/down counter datapath (load_n, data_load, ce, up_down, with count_out/max_count/zero status).
- Accepts one command at a time over a valid/ready handshake: start value, target value, direction, inter-step gap.
- Loads the counter, then pulses ce one step at a time until count_out equals the target, and reports done, wrap and abort status.
- Sits between a host/test controller and one counter instance; shares the counter's clk and rst_n.

Parameters:
WIDTH, 4, counter data width; must equal the attached counter's WIDTH
GAP_W, 4, width of the inter-step gap field

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_start  in  WIDTH  value loaded into the counter
cmd_target  in  WIDTH  terminal count value
cmd_up  in  1  1 = count up, 0 = count down
cmd_gap  in  GAP_W  idle cycles inserted between consecutive ce pulses
abort  in  1  cancel the active command
load_n  out  1  to counter; active-low synchronous load
data_load  out  WIDTH  to counter; load value
ce  out  1  to counter; count enable
up_down  out  1  to counter; direction
count_out  in  WIDTH  from counter; current count
max_count  in  1  from counter; count_out is all ones
zero  in  1  from counter; count_out is 0
busy  out  1  a command is in progress (LOAD/RUN/DONE)
done  out  1  one-cycle pulse: target reached
aborted  out  1  one-cycle pulse: command cancelled
wrapped  out  1  sticky per command: a step crossed the max->0 or 0->max boundary

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset: state=IDLE, cmd_ready=1, load_n=1, ce=0, data_load=0, up_down=1, busy=0, done=0, aborted=0, wrapped=0, all latched fields=0.
- Reset mid-operation: immediate return to the reset values. No done or aborted pulse.
- Outputs are Moore, decoded from registered state and latched fields.

State machine:
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch start, target, up and gap, clear wrapped, and go to LOAD.
  - A cmd_valid arriving while busy is not accepted; cmd_ready is low.
- LOAD (exactly 1 cycle):
  - load_n=0, data_load=start_r, up_down=up_r, ce=0.
  - gap_cnt <= gap_r.
  - Next state RUN.
- RUN:
  - Priority 1: abort=1 -> IDLE next cycle. ce=0 this cycle. aborted pulses in the following cycle; done does not pulse.
  - Priority 2: count_out==target_r -> DONE. ce=0.
  - Priority 3: gap_cnt==0 -> ce=1 this cycle, gap_cnt <= gap_r. If (up_r && max_count) || (!up_r && zero), set wrapped.
  - Otherwise gap_cnt <= gap_cnt-1, ce=0.
- DONE (1 cycle): done=1, then IDLE.
- abort during LOAD: the load still completes (load_n=0 this cycle), then go to IDLE with an aborted pulse. abort in IDLE or DONE is ignored.
- up_down holds up_r from LOAD through RUN. load_n=1 and ce=0 in every state other than those noted above.
- Target comparison uses registered count_out. A ce issued in cycle t is visible at t+1, so overshoot is impossible even with gap=0.
- Step count N:
  - Up: (target-start) mod 2^WIDTH.
  - Down: (start-target) mod 2^WIDTH.
  - Counting wraps modulo 2^WIDTH, so every target is reachable.
- Latency, with the handshake cycle as cycle 0 and G = gap:
  - LOAD is cycle 1.
  - ce pulses occur at cycles 2+G+k(G+1), for k=0..N-1.
  - done is asserted at cycle 3+N(G+1).
  - The next command can be accepted at cycle 4+N(G+1).
- start==target (N=0): no ce pulse; done at cycle 3.
- busy=1 in LOAD, RUN and DONE.

Test Plan:
- WIDTH=4. cmd start=3, target=7, up=1, gap=0 -> ce pulses at cycles 2..5, count_out 3->7, done at cycle 7, wrapped=0.
- start=14, target=1, up=1, gap=0 -> N=3 (14,15,0,1), done at cycle 6, wrapped=1 (step issued while max_count=1).
- start=2, target=2 -> no ce pulse, done at cycle 3. Then start=5, target=3, up=0, gap=2 -> ce at cycles 4 and 7, done at cycle 9, count_out=3.
- start=0, target=8, up=1, gap=1; abort=1 in cycle 6 -> no ce in cycle 6, aborted pulse in cycle 7, done never asserts, count_out frozen at 2, cmd_ready=1 in cycle 7.
- Second cmd_valid held high while busy -> not accepted until IDLE. Then it is accepted in the cycle after done, with its fields unchanged.
- rst_n low mid-RUN (count_out=5) -> same-cycle asynchronous return to IDLE, ce=0, load_n=1, busy=0, no done. Counter resets to 0 on the same rst_n.
